// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver. Each digit slot opens with a blanking window.
// New data is staged in shadow registers and takes effect only at frame boundaries.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 4096,
    parameter int BLANK_CYC  = 1024,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dot_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [6:0]                seg,
    output logic                      dot,
    output logic [NUM_DIGITS-1:0]     led,
    output logic                      frame_start
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
    localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
    localparam logic          POL        = ACTIVE_LOW;

    logic [SW-1:0]             slot_cnt;
    logic [DW-1:0]             dig_idx;
    logic                      pending;
    logic [4*NUM_DIGITS-1:0]   data_sh, data_act;
    logic [NUM_DIGITS-1:0]     dot_sh, dot_act;
    logic [NUM_DIGITS-1:0]     blank_sh, blank_act;
    logic                      boundary;
    logic                      lit;
    logic [3:0]                nibble;
    logic [6:0]                seg_nx;
    logic                      dot_nx;
    logic [NUM_DIGITS-1:0]     led_nx;

    // Segment pattern for a hex nibble, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign boundary = (slot_cnt == SLOT_LAST) && (dig_idx == DIG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // A load coinciding with the boundary bypasses the shadow so it lands in the very next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            data_sh   <= '0;
            dot_sh    <= '0;
            blank_sh  <= '0;
            data_act  <= '0;
            dot_act   <= '0;
            blank_act <= '0;
        end else begin
            if (load) begin
                data_sh  <= data_in;
                dot_sh   <= dot_in;
                blank_sh <= blank_in;
                pending  <= 1'b1;
            end
            if (boundary && (pending || load)) begin
                data_act  <= load ? data_in  : data_sh;
                dot_act   <= load ? dot_in   : dot_sh;
                blank_act <= load ? blank_in : blank_sh;
                pending   <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble = data_act[{dig_idx, 2'b00} +: 4];
        lit    = (slot_cnt >= BLANK_END) && !blank_act[dig_idx];
        led_nx = lit ? (NUM_DIGITS'(1) << dig_idx) : '0;
        seg_nx = lit ? hex7(nibble) : '0;
        dot_nx = lit && dot_act[dig_idx];
    end

    // Output stage: registered, polarity applied here; reset drives everything dark at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= {7{POL}};
            dot         <= POL;
            led         <= {NUM_DIGITS{POL}};
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_nx ^ {7{POL}};
            dot         <= dot_nx ^ POL;
            led         <= led_nx ^ {NUM_DIGITS{POL}};
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver with a frame-level behavioural model and literal anchors.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dot_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg;
    logic        dot;
    logic [3:0]  led;
    logic        frame_start;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dot_in(dot_in),
        .blank_in(blank_in), .seg(seg), .dot(dot), .led(led), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    string seg_txt [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] hex_segs(input logic [3:0] v);
        string s;
        logic [6:0] r;
        s = seg_txt[v];
        r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    // Model: n counts cycles since reset release; digit/slot follow by plain division.
    function automatic bit m_lit(input int k, input logic [3:0] blk);
        return ((k % SD) >= BC) && !blk[(k / SD) % ND];
    endfunction

    function automatic logic [3:0] m_led(input int k, input logic [3:0] blk);
        return m_lit(k, blk) ? ~(4'b0001 << ((k / SD) % ND)) : 4'hF;
    endfunction

    function automatic logic [6:0] m_seg(input int k, input logic [3:0] blk, input logic [15:0] d);
        return m_lit(k, blk) ? ~hex_segs(d[((k / SD) % ND) * 4 +: 4]) : 7'h7F;
    endfunction

    function automatic logic m_dot(input int k, input logic [3:0] blk, input logic [3:0] dt);
        return m_lit(k, blk) ? ~dt[(k / SD) % ND] : 1'b1;
    endfunction

    int          n;
    logic [15:0] sh_data, act_data;
    logic [3:0]  sh_dot, act_dot, sh_blank, act_blank;
    logic        pend;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_led;
    logic        exp_dot, exp_fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0; pend <= 1'b0;
            sh_data <= '0; sh_dot <= '0; sh_blank <= '0;
            act_data <= '0; act_dot <= '0; act_blank <= '0;
            exp_seg <= 7'h7F; exp_led <= 4'hF; exp_dot <= 1'b1; exp_fs <= 1'b0;
        end else begin
            exp_seg <= m_seg(n, act_blank, act_data);
            exp_led <= m_led(n, act_blank);
            exp_dot <= m_dot(n, act_blank, act_dot);
            exp_fs  <= (n % FRAME) == FRAME - 1;
            if (load) begin
                sh_data <= data_in; sh_dot <= dot_in; sh_blank <= blank_in; pend <= 1'b1;
            end
            if ((n % FRAME) == FRAME - 1 && (pend || load)) begin
                act_data  <= load ? data_in  : sh_data;
                act_dot   <= load ? dot_in   : sh_dot;
                act_blank <= load ? blank_in : sh_blank;
                pend <= 1'b0;
            end
            n <= n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            check("model_seg", 32'(seg), 32'(exp_seg));
            check("model_led", 32'(led), 32'(exp_led));
            check("model_dot", 32'(dot), 32'(exp_dot));
            check("model_frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bl);
        @(negedge clk);
        load = 1'b1; data_in = d; dot_in = dt; blank_in = bl;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 100);
        if (frame_start !== 1'b1) check("wait_frame_start_timeout", 32'(k), 32'd0);
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while ((n % FRAME) != ph && k < 100) begin
            @(negedge clk);
            k++;
        end
        if ((n % FRAME) != ph) check("wait_phase_timeout", 32'(n % FRAME), 32'(ph));
    endtask

    initial begin
        int k;
        #1 rst = 1'b1;
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_led", 32'(led), 32'hF);
        check("reset_dot", 32'(dot), 32'h1);
        check("reset_fs", 32'(frame_start), 32'h0);
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 100);
        check("first_frame_start_latency", 32'(k), 32'd32);

        // Digit 0 shows 2 with its dot, digit 3 shows A.
        do_load(16'hA1B2, 4'b0001, 4'b0000);
        wait_fs();
        repeat (3) @(negedge clk);
        check("d0_led", 32'(led), 32'hE);
        check("d0_seg_2", 32'(seg), 32'h24);
        check("d0_dot_lit", 32'(dot), 32'h0);
        repeat (24) @(negedge clk);
        check("d3_led", 32'(led), 32'h7);
        check("d3_seg_A", 32'(seg), 32'h08);
        check("d3_dot_dark", 32'(dot), 32'h1);

        // Mid-frame load must not disturb the current frame.
        do_load(16'h1234, 4'b0000, 4'b0000);
        check("no_tear_seg_A", 32'(seg), 32'h08);
        wait_fs();
        repeat (3) @(negedge clk);
        check("new_frame_seg_4", 32'(seg), 32'h19);

        do_load(16'h1234, 4'b0000, 4'b0100);
        wait_fs();
        repeat (19) @(negedge clk);
        check("blank_slot2_led", 32'(led), 32'hF);
        check("blank_slot2_seg", 32'(seg), 32'h7F);

        // Last of two loads wins; a boundary-cycle load shows next frame.
        do_load(16'h1111, 4'b0000, 4'b0000);
        do_load(16'h2222, 4'b0000, 4'b0000);
        wait_fs();
        repeat (3) @(negedge clk);
        check("last_load_wins", 32'(seg), 32'h24);
        wait_phase(FRAME - 1);
        load = 1'b1; data_in = 16'h3333; dot_in = 4'b0000; blank_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        check("boundary_load_fs", 32'(frame_start), 32'h1);
        repeat (3) @(negedge clk);
        check("boundary_load_seg_3", 32'(seg), 32'h30);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 5) == 0);
            data_in = 16'($urandom);
            dot_in = 4'($urandom);
            blank_in = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        load = 1'b0;

        // Reset in slot 1, cycle 4, while digit 1 is lit.
        do_load(16'h5678, 4'b0000, 4'b0000);
        wait_fs();
        wait_phase(SD + 4);
        check("pre_reset_led", 32'(led), 32'hD);
        rst = 1'b1;
        #1;
        check("async_reset_seg", 32'(seg), 32'h7F);
        check("async_reset_led", 32'(led), 32'hF);
        check("async_reset_dot", 32'(dot), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_blank_led", 32'(led), 32'hF);
        repeat (2) @(negedge clk);
        check("restart_d0_led", 32'(led), 32'hE);
        check("restart_d0_seg_0", 32'(seg), 32'h40);
        repeat (40) @(negedge clk);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
